// File: rtl/hp_fifo.sv
// Host-to-parasite byte FIFO with first-word fall-through output.
// The host pushes on its clock-enable phase, the parasite pops on its own phase.
module hp_fifo #(
   parameter int         DEPTH     = 4,
   parameter int         AW        = 2,
   parameter logic [7:0] EMPTY_VAL = 8'hAA
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          h_cke,
   input  logic          h_selectData,
   input  logic          h_rdnw,
   input  logic [7:0]    h_data,
   input  logic          h_flush,
   input  logic          p_cke,
   input  logic          p_selectData,
   input  logic          p_rd,
   output logic [7:0]    p_data,
   output logic          p_data_available,
   output logic          h_full,
   output logic [AW:0]   count
);

   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic [AW-1:0] wr_ptr_next;
   logic [AW-1:0] rd_ptr_next;
   logic [AW:0]   count_next;
   logic          wr;
   logic          rd;

   // Flags come from the registered count, so the strobes are qualified by
   // the state that existed before this edge.
   assign h_full           = (count_reg == FULL_COUNT);
   assign p_data_available = (count_reg != '0);
   assign count            = count_reg;

   assign wr = h_cke & h_selectData & ~h_rdnw & ~h_full;
   assign rd = p_cke & p_selectData & p_rd & p_data_available;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (h_flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         // DEPTH is a power of two, so natural overflow gives the modulo wrap.
         if (wr) wr_ptr_next = wr_ptr_reg + PTR_ONE;
         if (rd) rd_ptr_next = rd_ptr_reg + PTR_ONE;
         if (wr && !rd)      count_next = count_reg + CNT_ONE;
         else if (rd && !wr) count_next = count_reg - CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Storage is never reset; stale bytes are hidden by the empty override.
   always_ff @(posedge clk) begin
      if (wr && !h_flush && !rst)
         mem[wr_ptr_reg] <= h_data;
   end

   assign p_data = (count_reg == '0) ? EMPTY_VAL : mem[rd_ptr_reg];

endmodule

// File: tb/tb_hp_fifo.sv
// Directed bench for hp_fifo (DEPTH=4): a vector table for single-cycle
// behaviour plus hand sequences for wrap, async reset and strobes under reset.
module tb_hp_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       h_cke = 1'b0, h_selectData = 1'b0, h_rdnw = 1'b0, h_flush = 1'b0;
   logic [7:0] h_data = 8'h00;
   logic       p_cke = 1'b0, p_selectData = 1'b0, p_rd = 1'b0;
   logic [7:0] p_data;
   logic       p_data_available;
   logic       h_full;
   logic [2:0] count;

   int checks   = 0;
   int failures = 0;

   hp_fifo #(.DEPTH(4), .AW(2), .EMPTY_VAL(8'hAA)) dut (
      .clk              (clk),
      .rst              (rst),
      .h_cke            (h_cke),
      .h_selectData     (h_selectData),
      .h_rdnw           (h_rdnw),
      .h_data           (h_data),
      .h_flush          (h_flush),
      .p_cke            (p_cke),
      .p_selectData     (p_selectData),
      .p_rd             (p_rd),
      .p_data           (p_data),
      .p_data_available (p_data_available),
      .h_full           (h_full),
      .count            (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       hc, hs, hrdnw;
      logic [7:0] hd;
      logic       fl, pc, ps, prd;
      logic [7:0] e_pd;
      logic       e_av, e_full;
      logic [2:0] e_cnt;
   } vec_t;

   localparam int NVEC = 22;
   vec_t vec [NVEC];

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%02h expected=%02h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic [7:0] pd, input logic av,
                          input logic fu, input logic [2:0] cn);
      $display("txn %-14s p_data=%02h avail=%0b full=%0b count=%0d",
               nm, p_data, p_data_available, h_full, count);
      chk({nm, ".p_data"}, p_data, pd);
      chk({nm, ".avail"}, {7'b0, p_data_available}, {7'b0, av});
      chk({nm, ".full"}, {7'b0, h_full}, {7'b0, fu});
      chk({nm, ".count"}, {5'b0, count}, {5'b0, cn});
   endtask

   task automatic drive(input logic hc, input logic hs, input logic hrdnw, input logic [7:0] hd,
                        input logic fl, input logic pc, input logic ps, input logic prd);
      h_cke = hc; h_selectData = hs; h_rdnw = hrdnw; h_data = hd;
      h_flush = fl; p_cke = pc; p_selectData = ps; p_rd = prd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          name           hc hs rw data   fl pc ps rd  p_data av fu cnt
      vec[0]  = '{"idle",        0, 0, 0, 8'h00, 0, 0, 0, 0, 8'hAA, 0, 0, 3'd0};
      vec[1]  = '{"wr11",        1, 1, 0, 8'h11, 0, 0, 0, 0, 8'h11, 1, 0, 3'd1};
      vec[2]  = '{"wr22",        1, 1, 0, 8'h22, 0, 0, 0, 0, 8'h11, 1, 0, 3'd2};
      vec[3]  = '{"wr33",        1, 1, 0, 8'h33, 0, 0, 0, 0, 8'h11, 1, 0, 3'd3};
      vec[4]  = '{"wr44_full",   1, 1, 0, 8'h44, 0, 0, 0, 0, 8'h11, 1, 1, 3'd4};
      vec[5]  = '{"wr55_drop",   1, 1, 0, 8'h55, 0, 0, 0, 0, 8'h11, 1, 1, 3'd4};
      vec[6]  = '{"wr_rd_full",  1, 1, 0, 8'h66, 0, 1, 1, 1, 8'h22, 1, 0, 3'd3};
      vec[7]  = '{"rd_22",       0, 0, 0, 8'h00, 0, 1, 1, 1, 8'h33, 1, 0, 3'd2};
      vec[8]  = '{"wr_rd_mid",   1, 1, 0, 8'h77, 0, 1, 1, 1, 8'h44, 1, 0, 3'd2};
      vec[9]  = '{"wr_no_hcke",  0, 1, 0, 8'h99, 0, 0, 0, 0, 8'h44, 1, 0, 3'd2};
      vec[10] = '{"host_read",   1, 1, 1, 8'h98, 0, 0, 0, 0, 8'h44, 1, 0, 3'd2};
      vec[11] = '{"rd_no_pcke",  0, 0, 0, 8'h00, 0, 0, 1, 1, 8'h44, 1, 0, 3'd2};
      vec[12] = '{"rd_no_prd",   0, 0, 0, 8'h00, 0, 1, 1, 0, 8'h44, 1, 0, 3'd2};
      vec[13] = '{"rd_44",       0, 0, 0, 8'h00, 0, 1, 1, 1, 8'h77, 1, 0, 3'd1};
      vec[14] = '{"rd_77",       0, 0, 0, 8'h00, 0, 1, 1, 1, 8'hAA, 0, 0, 3'd0};
      vec[15] = '{"rd_empty",    0, 0, 0, 8'h00, 0, 1, 1, 1, 8'hAA, 0, 0, 3'd0};
      vec[16] = '{"wr_rd_empty", 1, 1, 0, 8'h5A, 0, 1, 1, 1, 8'h5A, 1, 0, 3'd1};
      vec[17] = '{"wr01",        1, 1, 0, 8'h01, 0, 0, 0, 0, 8'h5A, 1, 0, 3'd2};
      vec[18] = '{"wr02",        1, 1, 0, 8'h02, 0, 0, 0, 0, 8'h5A, 1, 0, 3'd3};
      vec[19] = '{"flush_wr_rd", 1, 1, 0, 8'h03, 1, 1, 1, 1, 8'hAA, 0, 0, 3'd0};
      vec[20] = '{"wrC3",        1, 1, 0, 8'hC3, 0, 0, 0, 0, 8'hC3, 1, 0, 3'd1};
      vec[21] = '{"rd_C3",       0, 0, 0, 8'h00, 0, 1, 1, 1, 8'hAA, 0, 0, 3'd0};

      // Reset asserted before any clock edge: outputs must settle immediately.
      #1 rst = 1'b1;
      #2 chk_all("reset_async", 8'hAA, 1'b0, 1'b0, 3'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         drive(vec[i].hc, vec[i].hs, vec[i].hrdnw, vec[i].hd,
               vec[i].fl, vec[i].pc, vec[i].ps, vec[i].prd);
         step();
         chk_all(vec[i].name, vec[i].e_pd, vec[i].e_av, vec[i].e_full, vec[i].e_cnt);
      end

      // Ten write/read pairs walk the pointers round the ring twice.
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 0, 8'(i), 0, 0, 0, 0);
         step();
         chk_all($sformatf("wrap_wr%0d", i), 8'(i), 1'b1, 1'b0, 3'd1);
         drive(0, 0, 0, 8'h00, 0, 1, 1, 1);
         step();
         chk_all($sformatf("wrap_rd%0d", i), 8'hAA, 1'b0, 1'b0, 3'd0);
      end

      // Short reset pulse between edges with two bytes queued.
      drive(1, 1, 0, 8'hAB, 0, 0, 0, 0);
      step();
      drive(1, 1, 0, 8'hCD, 0, 0, 0, 0);
      step();
      chk_all("pre_rst", 8'hAB, 1'b1, 1'b0, 3'd2);
      drive(0, 0, 0, 8'h00, 0, 0, 0, 0);
      #2 rst = 1'b1;
      #1 chk_all("rst_pulse", 8'hAA, 1'b0, 1'b0, 3'd0);
      #1 rst = 1'b0;
      step();
      chk_all("post_rst_idle", 8'hAA, 1'b0, 1'b0, 3'd0);

      // Strobes held across an edge during reset are ignored; the first
      // edge after release accepts the write.
      drive(1, 1, 0, 8'hEE, 0, 1, 1, 1);
      rst = 1'b1;
      step();
      chk_all("strobe_in_rst", 8'hAA, 1'b0, 1'b0, 3'd0);
      rst = 1'b0;
      drive(1, 1, 0, 8'hEE, 0, 0, 0, 0);
      step();
      chk_all("first_wr", 8'hEE, 1'b1, 1'b0, 3'd1);
      drive(0, 0, 0, 8'h00, 0, 0, 0, 0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
